// File: rtl/sma_window_reader_if.sv
// Handshake bundle between the price source, the SMA window reader and the downstream averager.
interface sma_window_reader_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int SUMW = WIDTH + $clog2(DEPTH);

  // Both sides use valid/ready: a transfer happens on a rising edge where valid
  // and ready are both 1; a holder of valid keeps its data stable until then.
  logic             in_valid;
  logic [WIDTH-1:0] in_price;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_evicted;
  logic             out_evict_valid;
  logic [SUMW-1:0]  out_sum;
  logic [WIDTH-1:0] out_avg;
  logic             out_full;

  modport master (
    output in_valid, in_price, out_ready,
    input  in_ready, out_valid, out_evicted, out_evict_valid, out_sum, out_avg, out_full
  );

  modport slave (
    input  in_valid, in_price, out_ready,
    output in_ready, out_valid, out_evicted, out_evict_valid, out_sum, out_avg, out_full
  );
endinterface

// File: rtl/sma_window_reader.sv
// Circular price window with running sum; emits evicted sample, sum and average per accepted price.
module sma_window_reader #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input logic               clk,
  input logic               reset,
  sma_window_reader_if.slave bus
);
  localparam int AW   = $clog2(DEPTH);
  localparam int SUMW = WIDTH + AW;

  logic [WIDTH-1:0] window [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic [SUMW-1:0]  sum;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_evicted_q;
  logic             out_evict_valid_q;
  logic [SUMW-1:0]  out_sum_q;
  logic [WIDTH-1:0] out_avg_q;
  logic             out_full_q;

  logic             in_ready;
  logic             accept;
  logic             full;
  logic [WIDTH-1:0] evicted;
  logic [SUMW-1:0]  sum_next;
  logic [AW:0]      count_next;

  assign in_ready   = bus.out_ready | ~out_valid_q;
  assign accept     = bus.in_valid & in_ready;
  assign full       = (count == (AW+1)'(DEPTH));
  assign evicted    = full ? window[wr_ptr] : '0;
  // Subtracting the evicted sample keeps the sum bounded by DEPTH*(2^WIDTH-1).
  assign sum_next   = sum + SUMW'(bus.in_price) - SUMW'(evicted);
  assign count_next = full ? count : count + 1'b1;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [WIDTH-1:0] entry;
    always_ff @(posedge clk) begin
      if (reset) begin
        entry <= '0;
      end else if (accept && (wr_ptr == AW'(i))) begin
        entry <= bus.in_price;
      end
    end
    assign window[i] = entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      count  <= '0;
      sum    <= '0;
    end else if (accept) begin
      wr_ptr <= wr_ptr + 1'b1;
      count  <= count_next;
      sum    <= sum_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q       <= 1'b0;
      out_evicted_q     <= '0;
      out_evict_valid_q <= 1'b0;
      out_sum_q         <= '0;
      out_avg_q         <= '0;
      out_full_q        <= 1'b0;
    end else if (accept) begin
      out_valid_q       <= 1'b1;
      out_evicted_q     <= evicted;
      out_evict_valid_q <= full;
      out_sum_q         <= sum_next;
      out_avg_q         <= WIDTH'(sum_next >> AW);
      out_full_q        <= (count_next == (AW+1)'(DEPTH));
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready        = in_ready;
  assign bus.out_valid       = out_valid_q;
  assign bus.out_evicted     = out_evicted_q;
  assign bus.out_evict_valid = out_evict_valid_q;
  assign bus.out_sum         = out_sum_q;
  assign bus.out_avg         = out_avg_q;
  assign bus.out_full        = out_full_q;
endmodule

// File: tb/tb_sma_window_reader.sv
// Bench for sma_window_reader: directed plan plus randomized bubbles against a window-queue model.
module tb_sma_window_reader;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  sma_window_reader_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  sma_window_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: the last <=DEPTH accepted prices plus the expected output bundle
  logic [WIDTH-1:0] exp_q[$];
  logic             exp_out_valid;
  logic [WIDTH-1:0] exp_evicted;
  logic             exp_evict_valid;
  int               exp_sum;
  logic             exp_full;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int window_sum();
    int s = 0;
    foreach (exp_q[i]) s += int'(exp_q[i]);
    return s;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(exp_out_valid));
    if (exp_out_valid) begin
      chk({tag, ".evicted"},     32'(bus.out_evicted),     32'(exp_evicted));
      chk({tag, ".evict_valid"}, 32'(bus.out_evict_valid), 32'(exp_evict_valid));
      chk({tag, ".sum"},         32'(bus.out_sum),         32'(exp_sum));
      chk({tag, ".avg"},         32'(bus.out_avg),         32'(exp_sum / DEPTH));
      chk({tag, ".full"},        32'(bus.out_full),        32'(exp_full));
    end
  endtask

  // driver: one clock cycle with the given inputs, model update and output check
  task automatic step(input logic v, input logic [WIDTH-1:0] price, input logic ordy, input string tag);
    logic exp_ready;
    logic acc;
    bus.in_valid  = v;
    bus.in_price  = price;
    bus.out_ready = ordy;
    #1;
    exp_ready = ordy || !exp_out_valid;
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(exp_ready));
    acc = v && exp_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      exp_evict_valid = (exp_q.size() == DEPTH);
      exp_evicted     = exp_evict_valid ? exp_q.pop_front() : '0;
      exp_q.push_back(price);
      exp_sum         = window_sum();
      exp_full        = (exp_q.size() == DEPTH);
      exp_out_valid   = 1'b1;
    end else if (ordy) begin
      exp_out_valid = 1'b0;
    end
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_price  = WIDTH'($urandom);
    bus.out_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    exp_out_valid = 1'b0;
    chk({tag, ".out_valid"},   32'(bus.out_valid),       32'd0);
    chk({tag, ".evicted"},     32'(bus.out_evicted),     32'd0);
    chk({tag, ".evict_valid"}, 32'(bus.out_evict_valid), 32'd0);
    chk({tag, ".sum"},         32'(bus.out_sum),         32'd0);
    chk({tag, ".avg"},         32'(bus.out_avg),         32'd0);
    chk({tag, ".full"},        32'(bus.out_full),        32'd0);
    chk({tag, ".in_ready"},    32'(bus.in_ready),        32'd1);
  endtask

  initial begin
    logic [31:0] held_sum;
    logic [WIDTH-1:0] held_evicted;
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_price  = '0;
    bus.out_ready = 1'b1;
    exp_out_valid = 1'b0;
    exp_sum       = 0;
    @(posedge clk);
    #1;
    do_reset("reset0");

    // fill 10..80
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, WIDTH'(10 * i), 1'b1, "fill");
      chk("fill.sum_const", 32'(bus.out_sum), 32'(5 * i * (i + 1)));
      chk("fill.full_const", 32'(bus.out_full), 32'(i == DEPTH));
    end
    chk("fill.avg45", 32'(bus.out_avg), 32'd45);

    // wrap
    step(1'b1, 16'd90, 1'b1, "wrap90");
    chk("wrap90.evicted", 32'(bus.out_evicted), 32'd10);
    chk("wrap90.evict_valid", 32'(bus.out_evict_valid), 32'd1);
    chk("wrap90.sum", 32'(bus.out_sum), 32'd440);
    chk("wrap90.avg", 32'(bus.out_avg), 32'd55);
    step(1'b1, 16'd100, 1'b1, "wrap100");
    chk("wrap100.evicted", 32'(bus.out_evicted), 32'd20);
    chk("wrap100.sum", 32'(bus.out_sum), 32'd520);

    // backpressure: bundle held, nothing accepted
    held_sum     = 32'(bus.out_sum);
    held_evicted = bus.out_evicted;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 16'd110, 1'b0, "stall");
      chk("stall.sum_held", 32'(bus.out_sum), held_sum);
      chk("stall.evicted_held", 32'(bus.out_evicted), 32'(held_evicted));
    end
    step(1'b1, 16'd110, 1'b1, "release");
    chk("release.sum", 32'(bus.out_sum), 32'd600);
    step(1'b0, 16'd0, 1'b1, "release_drain");

    // max values
    do_reset("reset_max");
    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 16'hFFFF, 1'b1, "max");
    chk("max.sum", 32'(bus.out_sum), 32'h7FFF8);
    chk("max.avg", 32'(bus.out_avg), 32'hFFFF);
    chk("max.evicted", 32'(bus.out_evicted), 32'hFFFF);

    // reset mid-stream, then refill with 4
    for (int i = 0; i < 5; i++) step(1'b1, WIDTH'($urandom), 1'b1, "pre_reset");
    do_reset("reset_mid");
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 16'd4, 1'b1, "fill4");
      chk("fill4.full_const", 32'(bus.out_full), 32'(i == DEPTH));
    end
    chk("fill4.sum", 32'(bus.out_sum), 32'd32);
    chk("fill4.avg", 32'(bus.out_avg), 32'd4);

    // bubbles with random backpressure
    for (int i = 0; i < 300; i++) begin
      step(1'(i % 2 == 0), WIDTH'($urandom), 1'($urandom_range(0, 1)), "bubble");
    end
    // random valid and ready, including stalls with valid held high
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), WIDTH'($urandom_range(0, 65535)), 1'($urandom_range(0, 3) != 0), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
